prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_csum.sv | 35 +++
 rtl/prog_loader.sv | 152 +++++++++++++++
 tb/tb_prog_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared loader state encoding and frame layout constants.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        INSTR = 3'd2,
        ARG   = 3'd3,
        CSUM  = 3'd4,
        FIN   = 3'd5
    } ld_state_e;

    // Frame layout: [len] then N x [instr arg] then [csum]
    localparam int FRM_LEN_POS   = 0;
    localparam int FRM_PAIR_BASE = 1;
    localparam int FRM_PAIR_SIZE = 2;
    localparam int FRM_INSTR_OFS = 0;
    localparam int FRM_ARG_OFS   = 1;

    function automatic int frm_csum_pos(input int n);
        return FRM_PAIR_BASE + FRM_PAIR_SIZE * n;
    endfunction

    function automatic logic ld_accepts(input ld_state_e s);
        return s inside {LEN, INSTR, ARG, CSUM};
    endfunction

endpackage

// File: rtl/prog_loader_csum.sv
// Modulo-2^WIDTH running sum of program bytes.
module ld_csum #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] byte_i,
    output logic [WIDTH-1:0] sum_o
);

    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (en_i) begin
            sum_d = sum_q + byte_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/prog_loader.sv
// Host-link program loader: frames bytes into program memory writes
// and holds the CPU in reset until a load checks out.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_instr,
    output logic [WIDTH-1:0] wr_arg,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err
);

    ld_state_e        state_q;
    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] rx_csum_q;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] wr_addr_q;
    logic [WIDTH-1:0] wr_instr_q;
    logic [WIDTH-1:0] wr_arg_q;
    logic             wr_en_q;
    logic             hold_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic xfer;
    logic start_ok;
    logic last_pair;
    logic csum_en;

    assign in_ready  = ld_accepts(state_q);
    assign xfer      = in_valid && in_ready;
    assign start_ok  = (state_q == IDLE) && start && !busy_q;
    assign cnt_d     = cnt_q + 1'b1;
    assign last_pair = (cnt_q == len_q - 1'b1);
    assign csum_en   = xfer && (state_q == INSTR || state_q == ARG);

    ld_csum #(
        .WIDTH (WIDTH)
    ) u_csum (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (start_ok),
        .en_i   (csum_en),
        .byte_i (in_data),
        .sum_o  (sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            instr_q    <= '0;
            rx_csum_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_instr_q <= '0;
            wr_arg_q   <= '0;
            hold_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= LEN;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        hold_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        len_q <= in_data;
                        if (in_data == '0) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= INSTR;
                        end
                    end
                end
                INSTR: begin
                    if (xfer) begin
                        instr_q <= in_data;
                        state_q <= ARG;
                    end
                end
                ARG: begin
                    if (xfer) begin
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= cnt_q;
                        wr_instr_q <= instr_q;
                        wr_arg_q   <= in_data;
                        cnt_q      <= cnt_d;
                        state_q    <= last_pair ? CSUM : INSTR;
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        rx_csum_q <= in_data;
                        state_q   <= FIN;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    // A failed load leaves the CPU held until a good one lands
                    if (rx_csum_q == sum) begin
                        done_q <= 1'b1;
                        hold_q <= 1'b0;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_instr = wr_instr_q;
    assign wr_arg   = wr_arg_q;
    assign cpu_hold = hold_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table frames, hand-written
// corner sequences and random frames against a frame-level model.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         wr_en;
    logic [W-1:0] wr_addr;
    logic [W-1:0] wr_instr;
    logic [W-1:0] wr_arg;
    logic         cpu_hold;
    logic         busy;
    logic         done;
    logic         err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [7:0]  fq[$];
    logic [23:0] wq[$];

    typedef struct {
        int n;
        int fill;
        int delta;
        int gap;
        int exp_done;
        int exp_err;
        int exp_wr;
    } vec_t;

    vec_t tbl[7];

    prog_loader #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_instr (wr_instr),
        .wr_arg   (wr_arg),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (wr_en) wq.push_back({wr_addr, wr_instr, wr_arg});
        if (done) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic build(input int n, input int fill, input int delta);
        logic [7:0] s;
        logic [7:0] b;
        s = 8'h00;
        fq.delete();
        fq.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) begin
            b = (fill < 0) ? 8'($urandom) : 8'(fill);
            fq.push_back(b);
            s = s + b;
        end
        if (n > 0) fq.push_back(s + 8'(delta));
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_bytes(input int count, input int mode);
        int idx;
        int budget;
        bit v;
        bit took;
        idx = 0;
        budget = 0;
        while (idx < count && budget < 4000) begin
            case (mode)
                1: v = (budget % 2) == 0;
                2: v = $urandom_range(0, 3) != 0;
                default: v = 1'b1;
            endcase
            in_valid = v;
            in_data = v ? fq[idx] : 8'($urandom);
            took = v && in_ready;
            @(negedge clk);
            if (took) idx++;
            budget++;
        end
        in_valid = 1'b0;
        check("send_timeout", idx, count);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check("idle_timeout", int'(busy), 0);
    endtask

    task automatic run_frame(input int mode);
        wq.delete();
        done_cnt = 0;
        do_start();
        send_bytes(fq.size(), mode);
        wait_idle();
    endtask

    task automatic model_check(input string tag);
        int n;
        int p;
        logic [7:0] s;
        bit ok;
        logic [23:0] e;
        n = int'(fq[FRM_LEN_POS]);
        s = 8'h00;
        for (int i = 0; i < n; i++) begin
            p = FRM_PAIR_BASE + FRM_PAIR_SIZE * i;
            s = s + fq[p + FRM_INSTR_OFS];
            s = s + fq[p + FRM_ARG_OFS];
        end
        ok = (n != 0) && (fq[frm_csum_pos(n)] == s);
        check($sformatf("%s_nwr", tag), wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            p = FRM_PAIR_BASE + FRM_PAIR_SIZE * i;
            e = {8'(i), fq[p + FRM_INSTR_OFS], fq[p + FRM_ARG_OFS]};
            check($sformatf("%s_wr%0d", tag, i), int'(wq[i]), int'(e));
        end
        check($sformatf("%s_done", tag), done_cnt, int'(ok));
        check($sformatf("%s_err", tag), int'(err), int'(!ok));
        check($sformatf("%s_hold", tag), int'(cpu_hold), int'(!ok));
        check($sformatf("%s_rdy", tag), int'(in_ready), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check($sformatf("%s_rdy", tag), int'(in_ready), 0);
        check($sformatf("%s_wren", tag), int'(wr_en), 0);
        check($sformatf("%s_busy", tag), int'(busy), 0);
        check($sformatf("%s_done", tag), int'(done), 0);
        check($sformatf("%s_err", tag), int'(err), 0);
        check($sformatf("%s_hold", tag), int'(cpu_hold), 1);
        check($sformatf("%s_wbus", tag),
              int'({wr_addr, wr_instr, wr_arg}), 0);
    endtask

    initial begin
        logic [23:0] last;
        int n;
        int delta;
        int mode;

        tbl[0] = '{1, -1, 0, 0, 1, 0, 1};
        tbl[1] = '{5, -1, 0, 2, 1, 0, 5};
        tbl[2] = '{4, 8'h80, 1, 0, 0, 1, 4};
        tbl[3] = '{3, -1, 8'hFF, 1, 0, 1, 3};
        tbl[4] = '{16, -1, 0, 2, 1, 0, 16};
        tbl[5] = '{2, 8'h00, 0, 0, 1, 0, 2};
        tbl[6] = '{0, -1, 0, 0, 0, 1, 0};

        repeat (2) @(negedge clk);
        check_reset_vals("rst0");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        fq = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        run_frame(0);
        model_check("good2");
        check("good2_w0", int'(wq.size() > 0 ? wq[0] : 24'h0), 24'h001122);
        check("good2_w1", int'(wq.size() > 1 ? wq[1] : 24'h0), 24'h013344);

        fq = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hCD};
        run_frame(0);
        model_check("bad2");
        check("bad2_err", int'(err), 1);

        fq = '{8'h00};
        run_frame(0);
        model_check("zero");
        check("zero_busy", int'(busy), 0);

        fq = '{8'h01, 8'hAA, 8'hBB, 8'h65};
        run_frame(1);
        model_check("tog");
        check("tog_w0", int'(wq.size() > 0 ? wq[0] : 24'h0), 24'h00AABB);

        for (int t = 0; t < 7; t++) begin
            build(tbl[t].n, tbl[t].fill, tbl[t].delta);
            run_frame(tbl[t].gap);
            check($sformatf("tbl%0d_done", t), done_cnt, tbl[t].exp_done);
            check($sformatf("tbl%0d_err", t), int'(err), tbl[t].exp_err);
            check($sformatf("tbl%0d_nwr", t), wq.size(), tbl[t].exp_wr);
            model_check($sformatf("tbl%0d", t));
        end

        fq = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h50};
        wq.delete();
        done_cnt = 0;
        do_start();
        send_bytes(4, 0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        check("midrst_nwr", wq.size(), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("midrst_nowr", wq.size(), 1);
        check("midrst_idle", int'(busy), 0);
        run_frame(0);
        model_check("reload");

        build(255, 1, 0);
        run_frame(0);
        model_check("ff");
        last = wq.size() > 0 ? wq[wq.size() - 1] : 24'h0;
        check("ff_last_addr", int'(last[23:16]), 8'hFE);
        check("ff_csum_byte", int'(fq[fq.size() - 1]), 8'hFE);

        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 12);
            delta = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 255) : 0;
            mode = $urandom_range(0, 2);
            build(n, -1, delta);
            run_frame(mode);
            model_check($sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
